// File: rtl/vdp_data_ifce_pkg.sv
// Shared definitions for the VDP host data port: status bit positions,
// VRAM address width, control-byte decode and the FSM/toggle encodings.
package vdp_data_ifce_pkg;

    localparam int VRAM_AW = 14;

    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

    // Second control byte, bits [7:6]; 2'b1x is a register write owned elsewhere.
    localparam logic [1:0] CTL_RDSET = 2'b00;
    localparam logic [1:0] CTL_WRSET = 2'b01;

    typedef enum logic {
        TOG_FIRST,
        TOG_SECOND
    } tog_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_RD,
        PEND_WR
    } pend_t;

    typedef enum logic {
        REQ_IDLE,
        REQ_BUSY
    } req_state_t;

endpackage

// File: rtl/vdp_status_reg.sv
// VDP status register: F / 5S / C flags, fifth-sprite number,
// clear-on-read and the registered interrupt output.
module vdp_status_reg
    import vdp_data_ifce_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rd1_tick,
    input  logic       frame_tick,
    input  logic       coinc_tick,
    input  logic       fifth_tick,
    input  logic [4:0] fifth_num,
    input  logic       int_en,
    output logic [7:0] status_out,
    output logic       irq
);

    logic       f_flag;
    logic       s5_flag;
    logic       c_flag;
    logic [4:0] num_reg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_flag  <= 1'b0;
            s5_flag <= 1'b0;
            c_flag  <= 1'b0;
            num_reg <= '0;
            irq     <= 1'b0;
        end else begin
            // A set arriving with the clearing read wins, so no event is lost.
            f_flag  <= frame_tick | (f_flag  & ~rd1_tick);
            s5_flag <= fifth_tick | (s5_flag & ~rd1_tick);
            c_flag  <= coinc_tick | (c_flag  & ~rd1_tick);
            if (fifth_tick && !s5_flag)
                num_reg <= fifth_num;
            irq <= int_en & f_flag;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        status_out        = '0;
        status_out[ST_F]  = f_flag;
        status_out[ST_5S] = s5_flag;
        status_out[ST_C]  = c_flag;
        status_out[4:0]   = num_reg;
    end

endmodule

// File: rtl/vdp_data_ifce.sv
// VDP host data port: control-byte address setup, read-ahead data buffer,
// single-slot VRAM request FSM with auto-increment, and the status register.
module vdp_data_ifce
    import vdp_data_ifce_pkg::*;
#(
    parameter int AW = VRAM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr0_tick,
    input  logic          rd0_tick,
    input  logic          wr1_tick,
    input  logic          rd1_tick,
    input  logic [7:0]    din,
    output logic [7:0]    data_out,
    output logic [7:0]    status_out,
    input  logic          frame_tick,
    input  logic          coinc_tick,
    input  logic          fifth_tick,
    input  logic [4:0]    fifth_num,
    input  logic          int_en,
    output logic          irq,
    output logic [AW-1:0] vram_addr,
    output logic          vram_we,
    output logic [7:0]    vram_wdata,
    output logic          vram_req,
    input  logic          vram_ack,
    input  logic [7:0]    vram_rdata
);

    tog_t          tog;
    pend_t         pend;
    pend_t         sched;
    pend_t         pend_eff;
    req_state_t    state;
    logic [7:0]    lo_reg;
    logic [7:0]    wbuf;
    logic [7:0]    wbuf_eff;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] addr_eff;
    logic [AW-1:0] setup_addr;
    logic          setup_hit;

    // The *_eff values let an idle FSM issue in the same edge that a host op lands.
    always_comb begin
        setup_hit  = wr1_tick && (tog == TOG_SECOND) &&
                     ((din[7:6] == CTL_RDSET) || (din[7:6] == CTL_WRSET));
        setup_addr = AW'({din[5:0], lo_reg});
        sched      = PEND_NONE;
        if (wr0_tick)
            sched = PEND_WR;
        else if (rd0_tick || (setup_hit && din[7:6] == CTL_RDSET))
            sched = PEND_RD;
        pend_eff = (sched != PEND_NONE) ? sched : pend;
        addr_eff = setup_hit ? setup_addr : addr_reg;
        wbuf_eff = wr0_tick ? din : wbuf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog        <= TOG_FIRST;
            pend       <= PEND_NONE;
            state      <= REQ_IDLE;
            lo_reg     <= '0;
            wbuf       <= '0;
            addr_reg   <= '0;
            data_out   <= '0;
            vram_req   <= 1'b0;
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
        end else begin
            // Any other port access re-synchronises the two-byte control sequence.
            if (wr1_tick) begin
                if (tog == TOG_FIRST) begin
                    lo_reg <= din;
                    tog    <= TOG_SECOND;
                end else begin
                    tog    <= TOG_FIRST;
                end
            end else if (rd0_tick || wr0_tick || rd1_tick) begin
                tog <= TOG_FIRST;
            end

            if (wr0_tick)
                wbuf <= din;

            if (setup_hit)
                addr_reg <= setup_addr;
            else if (state == REQ_BUSY && vram_ack)
                addr_reg <= addr_reg + AW'(1);

            pend <= pend_eff;

            case (state)
                REQ_IDLE: begin
                    if (pend_eff != PEND_NONE) begin
                        vram_req   <= 1'b1;
                        vram_addr  <= addr_eff;
                        vram_we    <= (pend_eff == PEND_WR);
                        vram_wdata <= wbuf_eff;
                        pend       <= PEND_NONE;
                        state      <= REQ_BUSY;
                    end
                end
                REQ_BUSY: begin
                    // vram_wdata, not wbuf, so a newer host write cannot leak in.
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        data_out <= vram_we ? vram_wdata : vram_rdata;
                        state    <= REQ_IDLE;
                    end
                end
                default: state <= REQ_IDLE;
            endcase
        end
    end

    vdp_status_reg u_status (
        .clk        (clk),
        .reset      (reset),
        .rd1_tick   (rd1_tick),
        .frame_tick (frame_tick),
        .coinc_tick (coinc_tick),
        .fifth_tick (fifth_tick),
        .fifth_num  (fifth_num),
        .int_en     (int_en),
        .status_out (status_out),
        .irq        (irq)
    );

endmodule

// File: tb/tb_vdp_data_ifce.sv
// Scoreboard bench for vdp_data_ifce: host ops push expected VRAM transactions,
// an arbiter/monitor process pops, compares and acknowledges them.
module tb_vdp_data_ifce;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr0_tick, rd0_tick, wr1_tick, rd1_tick;
    logic [7:0]    din;
    logic [7:0]    data_out, status_out;
    logic          frame_tick, coinc_tick, fifth_tick;
    logic [4:0]    fifth_num;
    logic          int_en, irq;
    logic [AW-1:0] vram_addr;
    logic          vram_we, vram_req, vram_ack;
    logic [7:0]    vram_wdata, vram_rdata;

    always #20 clk = ~clk;

    vdp_data_ifce #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr0_tick   (wr0_tick),
        .rd0_tick   (rd0_tick),
        .wr1_tick   (wr1_tick),
        .rd1_tick   (rd1_tick),
        .din        (din),
        .data_out   (data_out),
        .status_out (status_out),
        .frame_tick (frame_tick),
        .coinc_tick (coinc_tick),
        .fifth_tick (fifth_tick),
        .fifth_num  (fifth_num),
        .int_en     (int_en),
        .irq        (irq),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_req   (vram_req),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata)
    );

    typedef struct {
        logic [13:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [7:0]  dout;
        int          delay;
    } xact_t;

    xact_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: transaction-level view of the data port.
    bit          m_first;
    logic [7:0]  m_lo;
    logic [13:0] m_addr;
    logic [7:0]  m_dout;
    logic [7:0]  m_wbuf;
    int          m_pend;      // 0 none, 1 read, 2 write
    bit          defer_issue;
    int          nxt_delay;
    logic [7:0]  nxt_rdata;
    bit          inject_ack;
    bit          arb_busy;

    task automatic model_reset();
        m_first = 1; m_lo = 0; m_addr = 0; m_dout = 0; m_wbuf = 0; m_pend = 0;
    endtask

    task automatic issue_pending();
        xact_t x;
        if (m_pend != 0) begin
            x.addr  = m_addr;
            x.we    = (m_pend == 2);
            x.wdata = m_wbuf;
            x.rdata = nxt_rdata;
            x.delay = nxt_delay;
            x.dout  = x.we ? m_wbuf : nxt_rdata;
            m_dout  = x.dout;
            m_addr  = m_addr + 14'd1;
            m_pend  = 0;
            exp_q.push_back(x);
        end
    endtask

    task automatic host_ctl(input logic [7:0] b);
        @(negedge clk);
        din = b; wr1_tick = 1'b1;
        if (m_first) begin
            m_lo = b; m_first = 0;
        end else begin
            m_first = 1;
            if (!b[7]) begin
                m_addr = {b[5:0], m_lo};
                if (!b[6]) m_pend = 1;
            end
        end
        if (!defer_issue) issue_pending();
        @(negedge clk);
        wr1_tick = 1'b0;
    endtask

    task automatic host_rd0();
        @(negedge clk);
        rd0_tick = 1'b1;
        m_first = 1; m_pend = 1;
        if (!defer_issue) issue_pending();
        @(negedge clk);
        rd0_tick = 1'b0;
    endtask

    task automatic host_wr0(input logic [7:0] b);
        @(negedge clk);
        din = b; wr0_tick = 1'b1;
        m_first = 1; m_wbuf = b; m_pend = 2;
        if (!defer_issue) issue_pending();
        @(negedge clk);
        wr0_tick = 1'b0;
    endtask

    task automatic host_rd1();
        @(negedge clk);
        rd1_tick = 1'b1;
        m_first = 1;
        @(negedge clk);
        rd1_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || arb_busy || vram_req) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle reached in budget", 32'(k < 300), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Arbiter and monitor: pops the scoreboard on each new request.
    initial begin : arbiter
        xact_t cur;
        int    cnt = 0;
        bit    busy = 0;
        bit    acked = 0;
        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
        arb_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (acked) begin
                check("data_out after ack", data_out, cur.dout);
                check("req low after ack", vram_req, 0);
                acked = 0;
            end
            vram_ack = 1'b0;
            if (reset) begin
                busy = 0;
            end else begin
                if (vram_req && !busy) begin
                    check("request expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("req addr", vram_addr, cur.addr);
                        check("req we", vram_we, cur.we);
                        if (cur.we) check("req wdata", vram_wdata, cur.wdata);
                        busy = 1;
                        cnt  = cur.delay;
                    end else begin
                        vram_ack = 1'b1;
                    end
                end else if (busy) begin
                    check("addr stable while req", vram_addr, cur.addr);
                end
                if (busy) begin
                    if (cnt == 0) begin
                        vram_ack   = 1'b1;
                        vram_rdata = cur.rdata;
                        busy  = 0;
                        acked = 1;
                    end else begin
                        cnt--;
                    end
                end
                if (inject_ack) vram_ack = 1'b1;
            end
            arb_busy = busy;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b1;
        wr0_tick = 0; rd0_tick = 0; wr1_tick = 0; rd1_tick = 0; din = 0;
        frame_tick = 0; coinc_tick = 0; fifth_tick = 0; fifth_num = 0; int_en = 0;
        defer_issue = 0; inject_ack = 0; nxt_delay = 0; nxt_rdata = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset data_out", data_out, 0);
        check("reset status", status_out, 0);
        check("reset req", vram_req, 0);
        check("reset irq", irq, 0);
        check("reset addr", vram_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Read setup 0x1234, one-cycle ack.
        nxt_delay = 0; nxt_rdata = 8'hA5;
        host_ctl(8'h34);
        host_ctl(8'h12);
        check("read setup req next cycle", vram_req, 1);
        check("read setup addr", vram_addr, 14'h1234);
        wait_idle();
        check("read setup data_out", data_out, 8'hA5);
        nxt_rdata = 8'h3C;
        host_rd0();              // expected at 0x1235
        wait_idle();
        check("rd0 data_out", data_out, 8'h3C);

        // Write stream with wrap.
        host_ctl(8'hFF);
        host_ctl(8'h7F);
        host_wr0(8'h11);         // 0x3FFF
        wait_idle();
        host_wr0(8'h22);         // 0x0000
        wait_idle();
        check("write stream data_out", data_out, 8'h22);

        // Toggle re-sync through a status read.
        host_ctl(8'h22);
        host_rd1();
        host_ctl(8'h00);
        host_ctl(8'h40);
        repeat (3) @(negedge clk);
        check("write setup issues nothing", vram_req, 0);
        host_wr0(8'h5A);         // 0x0000
        wait_idle();

        // Status flags and irq.
        int_en = 1'b1;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        check("F set", status_out, 8'h80);
        check("irq lags F", irq, 0);
        @(negedge clk);
        check("irq follows F", irq, 1);
        rd1_tick = 1'b1; m_first = 1;
        #1 check("status during rd1", status_out, 8'h80);
        @(negedge clk); rd1_tick = 1'b0;
        check("status after rd1", status_out, 8'h00);
        @(negedge clk);
        check("irq clears", irq, 0);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b1; rd1_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; rd1_tick = 1'b0;
        check("F survives coincident rd1", status_out, 8'h80);
        host_rd1();
        check("F cleared", status_out, 8'h00);
        fifth_tick = 1'b1; fifth_num = 5'd7;
        @(negedge clk); fifth_num = 5'd9;
        @(negedge clk); fifth_tick = 1'b0;
        check("5S keeps first number", status_out, 8'h47);
        coinc_tick = 1'b1;
        @(negedge clk); coinc_tick = 1'b0;
        check("C set", status_out, 8'h67);
        host_rd1();
        check("flags cleared, num kept", status_out, 8'h07);
        fifth_tick = 1'b1;
        @(negedge clk); fifth_tick = 1'b0;
        check("5S reloads number", status_out, 8'h49);
        host_rd1();
        int_en = 1'b0;

        // Busy overlap: rd0 then wr0 while a long write is in flight.
        host_ctl(8'h10);
        host_ctl(8'h41);         // write setup 0x0110
        nxt_delay = 5;
        host_wr0(8'h77);
        defer_issue = 1;
        host_rd0();
        check("still busy during overlap", vram_req, 1);
        host_wr0(8'h99);
        defer_issue = 0;
        nxt_delay = 0;
        issue_pending();         // only the write survives, at 0x0111
        wait_idle();
        check("overlap data_out", data_out, 8'h99);

        // Asynchronous reset while busy.
        nxt_delay = 1000;
        host_wr0(8'h33);
        begin
            int k = 0;
            while (!arb_busy && k < 20) begin @(negedge clk); k++; end
            check("busy before reset", 32'(arb_busy), 1);
        end
        #5 reset = 1'b1;
        #1;
        check("reset drops req", vram_req, 0);
        check("reset data_out mid-busy", data_out, 0);
        check("reset vram_addr", vram_addr, 0);
        check("reset vram_we", vram_we, 0);
        check("reset vram_wdata", vram_wdata, 0);
        check("reset status mid-busy", status_out, 0);
        check("reset irq mid-busy", irq, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk); inject_ack = 1'b1;
        @(negedge clk); inject_ack = 1'b0;
        @(negedge clk);
        check("late ack ignored req", vram_req, 0);
        check("late ack ignored data", data_out, 0);
        nxt_delay = 2; nxt_rdata = 8'hC3;
        host_ctl(8'h05);
        host_ctl(8'h00);
        wait_idle();
        check("setup after reset", data_out, 8'hC3);

        // Randomized host traffic against the model.
        for (int i = 0; i < 200; i++) begin
            int op;
            logic [7:0] b;
            op = $urandom_range(0, 5);
            nxt_delay = $urandom_range(0, 3);
            nxt_rdata = 8'($urandom);
            b = 8'($urandom);
            case (op)
                0: host_ctl(b);
                1: host_ctl({1'b0, b[6:0]});
                2: host_rd0();
                3: host_wr0(b);
                4: host_rd1();
                default: begin
                    host_ctl({4'hF, b[3:0]});
                    host_ctl({1'b0, b[6], 6'h3F});
                end
            endcase
            wait_idle();
            check("random data_out", data_out, m_dout);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
